// File: rtl/i2s_dac_tx.sv
// I2S (Philips) transmitter for a WM8731 DAC in slave mode.
// Derives BCLK/DACLRCK from clk_i and shifts one latched stereo pair per frame.
module i2s_dac_tx #(
    parameter int VEC_WIDTH = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [VEC_WIDTH-1:0] l_data_i,
    input  logic [VEC_WIDTH-1:0] r_data_i,
    output logic                 sample_req_o,
    output logic                 aud_bclk_o,
    output logic                 aud_daclrck_o,
    output logic                 aud_dacdat_o
);

    localparam int BC_W = $clog2(2 * SLOT_BITS);
    localparam int HC_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(2 * SLOT_BITS - 1);
    localparam logic [BC_W-1:0] BC_SLOT = BC_W'(SLOT_BITS);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(BCLK_DIV - 1);

    logic [HC_W-1:0]      r_hc;
    logic                 r_bclk;
    logic [BC_W-1:0]      r_bc;
    logic [VEC_WIDTH-1:0] r_shl;
    logic [VEC_WIDTH-1:0] r_shr;
    logic                 r_lrck;
    logic                 r_dat;
    logic                 r_req;

    logic [HC_W-1:0]      w_hc_nxt;
    logic                 w_bclk_nxt;
    logic [BC_W-1:0]      w_bc_nxt;
    logic [VEC_WIDTH-1:0] w_shl_nxt;
    logic [VEC_WIDTH-1:0] w_shr_nxt;
    logic                 w_lrck_nxt;
    logic                 w_dat_nxt;
    logic                 w_req_nxt;

    logic [BC_W-1:0]      w_bc_inc;
    logic                 w_left;
    logic [BC_W-1:0]      w_k;
    logic [VEC_WIDTH-1:0] w_word;
    logic                 w_bit;
    logic                 w_fall;

    // Everything below is evaluated for the bit counter value after the falling event
    assign w_bc_inc = (r_bc == BC_LAST) ? '0 : r_bc + BC_W'(1);
    assign w_left   = (w_bc_inc < BC_SLOT);
    assign w_k      = w_left ? w_bc_inc : w_bc_inc - BC_SLOT;
    assign w_word   = w_left ? r_shl : r_shr;
    assign w_fall   = (r_hc == HC_LAST) && r_bclk;

    // k=0 is the I2S delay bit, k>VEC_WIDTH is padding; neither matches below
    always_comb begin
        w_bit = 1'b0;
        for (int i = 0; i < VEC_WIDTH; i++) begin
            if (int'(w_k) == VEC_WIDTH - i) begin
                w_bit = w_word[i];
            end
        end
    end

    always_comb begin
        w_hc_nxt   = r_hc;
        w_bclk_nxt = r_bclk;
        w_bc_nxt   = r_bc;
        w_shl_nxt  = r_shl;
        w_shr_nxt  = r_shr;
        w_lrck_nxt = r_lrck;
        w_dat_nxt  = r_dat;
        w_req_nxt  = 1'b0;
        if (!en_i) begin
            w_hc_nxt   = '0;
            w_bclk_nxt = 1'b0;
            w_bc_nxt   = BC_LAST;
            w_shl_nxt  = '0;
            w_shr_nxt  = '0;
            w_lrck_nxt = 1'b0;
            w_dat_nxt  = 1'b0;
        end else begin
            if (r_hc != HC_LAST) begin
                w_hc_nxt = r_hc + HC_W'(1);
            end else begin
                w_hc_nxt   = '0;
                w_bclk_nxt = ~r_bclk;
            end
            if (w_fall) begin
                w_bc_nxt   = w_bc_inc;
                w_lrck_nxt = ~w_left;
                w_dat_nxt  = w_bit;
                // Both channels latched together so the pair stays coherent
                if (w_bc_inc == '0) begin
                    w_shl_nxt = l_data_i;
                    w_shr_nxt = r_data_i;
                    w_req_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_hc   <= '0;
            r_bclk <= 1'b0;
            r_bc   <= BC_LAST;
            r_shl  <= '0;
            r_shr  <= '0;
            r_lrck <= 1'b0;
            r_dat  <= 1'b0;
            r_req  <= 1'b0;
        end else begin
            r_hc   <= w_hc_nxt;
            r_bclk <= w_bclk_nxt;
            r_bc   <= w_bc_nxt;
            r_shl  <= w_shl_nxt;
            r_shr  <= w_shr_nxt;
            r_lrck <= w_lrck_nxt;
            r_dat  <= w_dat_nxt;
            r_req  <= w_req_nxt;
        end
    end

    assign sample_req_o  = r_req;
    assign aud_bclk_o    = r_bclk;
    assign aud_daclrck_o = r_lrck;
    assign aud_dacdat_o  = r_dat;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx at default parameters.
// Decodes the serial stream on BCLK rising edges and checks frame timing.
module tb_i2s_dac_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] l_data = '0;
    logic [15:0] r_data = '0;
    logic        req;
    logic        bclk;
    logic        lrck;
    logic        dat;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int          cap_n;
    int          cap_lrerr;
    int          cap_edgeerr;
    logic [15:0] cap_l;
    logic [15:0] cap_r;
    logic        cap_pad;

    always #5 clk = ~clk;

    i2s_dac_tx #(
        .VEC_WIDTH(16),
        .SLOT_BITS(32),
        .BCLK_DIV (2)
    ) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .l_data_i     (l_data),
        .r_data_i     (r_data),
        .sample_req_o (req),
        .aud_bclk_o   (bclk),
        .aud_daclrck_o(lrck),
        .aud_dacdat_o (dat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_req(output int ok);
        ok = 0;
        for (int i = 0; i < 400 && ok == 0; i++) begin
            tick();
            if (req === 1'b1) ok = 1;
        end
    endtask

    // Call right after the req edge; collects 64 slot bits on BCLK rising edges
    task automatic capture(input int chg_j, input logic [15:0] chg_l);
        int   j;
        int   n;
        int   k;
        logic pb;
        logic pd;
        j = 0;
        n = 0;
        cap_l = '0;
        cap_r = '0;
        cap_pad = 1'b0;
        cap_lrerr = 0;
        cap_edgeerr = 0;
        pb = bclk;
        pd = dat;
        while (j < 64 && n < 400) begin
            tick();
            n++;
            if (dat !== pd && !(pb === 1'b1 && bclk === 1'b0)) cap_edgeerr++;
            if (pb === 1'b0 && bclk === 1'b1) begin
                k = j % 32;
                if (lrck !== (j >= 32)) cap_lrerr++;
                if (k >= 1 && k <= 16) begin
                    if (j < 32) cap_l = {cap_l[14:0], dat};
                    else        cap_r = {cap_r[14:0], dat};
                end else begin
                    cap_pad = cap_pad | (dat !== 1'b0);
                end
                if (j == chg_j) l_data = chg_l;
                j++;
            end
            pb = bclk;
            pd = dat;
        end
        cap_n = j;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        l_data = 16'h8001;
        r_data = 16'h7FFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({req, bclk, lrck, dat} !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_outs: got %b want 0000", {req, bclk, lrck, dat});
            end
        end
    endtask

    // Checks start-up timing then decodes the first frame
    task automatic test_start(input string nm);
        logic [3:0] bv;
        logic [3:0] rv;
        logic       ld;
        ld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            bv[i] = bclk;
            rv[i] = req;
            ld = ld | lrck | dat;
        end
        n_cmp++;
        if (bv !== 4'b0110) begin
            n_bad++;
            $display("FAIL %s_bclk: got %b want 0110", nm, bv);
        end
        n_cmp++;
        if (rv !== 4'b1000) begin
            n_bad++;
            $display("FAIL %s_req: got %b want 1000", nm, rv);
        end
        n_cmp++;
        if (ld !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_lrck_dat: got %b want 0", nm, ld);
        end
        capture(-1, 16'h0);
        n_cmp++;
        if (cap_n != 64) begin
            n_bad++;
            $display("FAIL %s_bits: got %0d want 64", nm, cap_n);
        end
        n_cmp++;
        if (cap_l !== 16'h8001) begin
            n_bad++;
            $display("FAIL %s_left: got %h want 8001", nm, cap_l);
        end
        n_cmp++;
        if (cap_r !== 16'h7FFE) begin
            n_bad++;
            $display("FAIL %s_right: got %h want 7ffe", nm, cap_r);
        end
        n_cmp++;
        if (cap_pad !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_pad: got %b want 0", nm, cap_pad);
        end
        n_cmp++;
        if (cap_lrerr != 0) begin
            n_bad++;
            $display("FAIL %s_lrck: got %0d errs want 0", nm, cap_lrerr);
        end
        n_cmp++;
        if (cap_edgeerr != 0) begin
            n_bad++;
            $display("FAIL %s_dat_edge: got %0d errs want 0", nm, cap_edgeerr);
        end
    endtask

    task automatic test_power_on();
        rst_n = 1'b1;
        test_start("pwr");
    endtask

    task automatic test_free_run();
        int   ok;
        int   reqs, bad_req, last_req;
        int   lr_high, lr_rise, bad_lr, last_lr;
        int   b_rise, bad_b, last_b;
        logic pb, pl;
        wait_req(ok);
        n_cmp++;
        if (ok != 1) begin
            n_bad++;
            $display("FAIL run_req_seen: got %0d want 1", ok);
        end
        reqs = 0; bad_req = 0; last_req = cyc;
        lr_high = 0; lr_rise = 0; bad_lr = 0; last_lr = -1;
        b_rise = 0; bad_b = 0; last_b = -1;
        pb = bclk;
        pl = lrck;
        for (int i = 0; i < 1024; i++) begin
            tick();
            if (lrck === 1'b1) lr_high++;
            if (pb === 1'b0 && bclk === 1'b1) begin
                b_rise++;
                if (last_b >= 0 && cyc - last_b != 4) bad_b++;
                last_b = cyc;
            end
            if (pl === 1'b0 && lrck === 1'b1) begin
                lr_rise++;
                if (last_lr >= 0 && cyc - last_lr != 256) bad_lr++;
                last_lr = cyc;
            end
            if (req === 1'b1) begin
                reqs++;
                if (cyc - last_req != 256) bad_req++;
                last_req = cyc;
            end
            pb = bclk;
            pl = lrck;
        end
        n_cmp++;
        if (reqs != 4) begin
            n_bad++;
            $display("FAIL run_req_cnt: got %0d want 4", reqs);
        end
        n_cmp++;
        if (bad_req != 0) begin
            n_bad++;
            $display("FAIL run_req_period: got %0d bad want 0", bad_req);
        end
        n_cmp++;
        if (lr_high != 512) begin
            n_bad++;
            $display("FAIL run_lrck_high: got %0d want 512", lr_high);
        end
        n_cmp++;
        if (lr_rise != 4 || bad_lr != 0) begin
            n_bad++;
            $display("FAIL run_lrck_period: got %0d rises %0d bad want 4 0", lr_rise, bad_lr);
        end
        n_cmp++;
        if (b_rise != 256 || bad_b != 0) begin
            n_bad++;
            $display("FAIL run_bclk_period: got %0d rises %0d bad want 256 0", b_rise, bad_b);
        end
    endtask

    task automatic test_mid_frame_change();
        int ok;
        wait_req(ok);
        capture(8, 16'h1234);
        n_cmp++;
        if (ok != 1 || cap_l !== 16'h8001) begin
            n_bad++;
            $display("FAIL chg_cur_left: got %h (req %0d) want 8001", cap_l, ok);
        end
        n_cmp++;
        if (cap_r !== 16'h7FFE) begin
            n_bad++;
            $display("FAIL chg_cur_right: got %h want 7ffe", cap_r);
        end
        wait_req(ok);
        capture(-1, 16'h0);
        n_cmp++;
        if (ok != 1 || cap_l !== 16'h1234) begin
            n_bad++;
            $display("FAIL chg_next_left: got %h (req %0d) want 1234", cap_l, ok);
        end
        n_cmp++;
        if (cap_r !== 16'h7FFE) begin
            n_bad++;
            $display("FAIL chg_next_right: got %h want 7ffe", cap_r);
        end
        l_data = 16'h8001;
    endtask

    task automatic test_enable_drop();
        int ok;
        int errs;
        wait_req(ok);
        for (int i = 0; i < 170; i++) tick();
        n_cmp++;
        if (ok != 1 || lrck !== 1'b1) begin
            n_bad++;
            $display("FAIL en_pre_right: got lrck %b (req %0d) want 1", lrck, ok);
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if ({req, bclk, lrck, dat} !== 4'b0000) begin
            n_bad++;
            $display("FAIL en_drop_outs: got %b want 0000", {req, bclk, lrck, dat});
        end
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if ({req, bclk, lrck, dat} !== 4'b0000) errs++;
        end
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL en_idle_quiet: got %0d busy cycles want 0", errs);
        end
        en = 1'b1;
        test_start("reen");
    endtask

    task automatic test_async_reset();
        int ok;
        wait_req(ok);
        tick();
        tick();
        n_cmp++;
        if (ok != 1 || bclk !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre_bclk: got %b (req %0d) want 1", bclk, ok);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req, bclk, lrck, dat} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_async_outs: got %b want 0000", {req, bclk, lrck, dat});
        end
        tick();
        n_cmp++;
        if ({req, bclk, lrck, dat} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_hold_outs: got %b want 0000", {req, bclk, lrck, dat});
        end
        rst_n = 1'b1;
        test_start("rst");
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_free_run();
        test_mid_frame_change();
        test_enable_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
